instr_issue_queue: RTL and testbench
====================================

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 Parameter DEPTH, default 64: queue entries, power of two and at least 2.
REQ-002 Parameter NUM_FPGA, default 64: FPGA count, power of two.
REQ-003 Parameter NUM_QUBIT_PER_FPGA, default 64: qubits per FPGA, power of two.
REQ-004 Parameter TIME_W, default 16: start_time and time-counter width.
REQ-005 Derived widths: OPW = clog2(NUM_FPGA*NUM_QUBIT_PER_FPGA), FW = clog2(NUM_FPGA), PW = clog2(DEPTH), IW = TIME_W+2+3*OPW+2.
REQ-006 clk  input  1  the block's single clock; reset is synchronous and active-high.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_instr  input  IW  instruction word {start_time, op_code[1:0], op_1, op_2, dest, status[1:0]}, MSB first.
REQ-009 in_valid  input  1  instruction offered.
REQ-010 in_ready  output  1  queue can accept.
REQ-011 out_valid  output  1  head entry eligible for issue.
REQ-012 out_ready  input  1  consumer accepts the issued instruction.
REQ-013 out_op_code  output  2  head op_code.
REQ-014 out_op_1, out_op_2, out_dest  output  OPW each  head operands.
REQ-015 out_op_1_fpga, out_op_2_fpga, out_dest_fpga  output  FW each  FPGA index of each operand.
REQ-016 out_lu_miss  output  1  at least one head operand has no valid lookup entry.
REQ-017 lu_we  input  1  lookup-table write strobe.
REQ-018 lu_addr  input  OPW  operand to map.
REQ-019 lu_fpga  input  FW  FPGA index to store.
REQ-020 count  output  PW+1  occupancy, 0..DEPTH.
REQ-021 queue_full, queue_empty, wrap_around  output  1 each  queue status flags.

Function
REQ-022 Head and tail pointers SHALL be PW+1 bits; wrap_around = head[PW] XOR tail[PW]; full = wrap_around AND low bits equal; empty = NOT wrap_around AND low bits equal.
REQ-023 in_ready SHALL equal NOT queue_full; enqueue occurs on in_valid AND in_ready, writing the entry at tail in that clock edge with status forced to 2'b00.
REQ-024 An internal TIME_W time counter SHALL increment every cycle and saturate at all-ones.
REQ-025 out_valid SHALL be combinational: NOT queue_empty AND head start_time <= time counter.
REQ-026 Dequeue occurs on out_valid AND out_ready; head advances at that edge, and all out_* fields SHALL reflect the entry at head, including the cycle in which out_valid is low.
REQ-027 Simultaneous enqueue and dequeue SHALL leave count unchanged; on a full queue, enqueue is refused (in_ready low) even when a dequeue occurs in the same cycle.
REQ-028 An entry written at cycle N SHALL first be visible at head at cycle N+1, never in the same cycle.
REQ-029 Lookup table: NUM_OPERANDS entries of {fpga[FW-1:0], valid}; lu_we writes {lu_fpga, 1} at lu_addr.
REQ-030 Lookup reads SHALL be combinational; a write and a read to the same address in the same cycle returns the old value.
REQ-031 Invalid lookup entries SHALL output fpga index 0 and set out_lu_miss; the instruction still issues.
REQ-032 Pointer increments SHALL wrap modulo 2*DEPTH; entries are never reordered.

Reset
REQ-033 While rst is high at a clock edge: head=0, tail=0, time counter=0, all lookup valid bits=0; queue storage is not cleared.
REQ-034 Reset-state outputs SHALL be: count=0, queue_empty=1, queue_full=0, wrap_around=0, in_ready=1, out_valid=0, out_lu_miss=1.
REQ-035 Reset mid-operation SHALL discard all queued entries, and any handshake in that cycle is ignored.

Configuration
REQ-036 Macro IIQ_OPLU_EN, when defined, SHALL compile in the lookup table as described in REQ-029 to REQ-031.
REQ-037 With IIQ_OPLU_EN undefined: no lookup storage; lu_* inputs ignored; each fpga output = operand[OPW-1:OPW-FW]; out_lu_miss tied 0.

Structure
REQ-038 A shared package iiq_pkg SHALL hold the OPW/FW/IW width functions and the instruction-field offset constants.
REQ-039 Sub-module oplu_table SHALL implement the lookup (one write port, three combinational read ports), instantiated only under IIQ_OPLU_EN.

Verification
Bench configuration: DEPTH=4, NUM_FPGA=4, NUM_QUBIT_PER_FPGA=4, TIME_W=16.
REQ-040 Fill test: 4 enqueues with start_time=0 and out_ready=0 -> count=4, queue_full=1, wrap_around=1, in_ready=0; a 5th in_valid is dropped.
REQ-041 Time gate: enqueue start_time=10 at cycle 0 after reset -> out_valid low until time counter=10, then high; pop with out_ready=1.
REQ-042 Wrap: 6 enqueue/dequeue pairs on a depth-4 queue -> FIFO order preserved, and wrap_around toggles as tail passes the MSB.
REQ-043 Simultaneous: count=2, enqueue and dequeue in the same cycle -> count stays 2; at count=4 the same action -> count=3.
REQ-044 Lookup (IIQ_OPLU_EN): write op 5 -> fpga 3; issue op_1=5, op_2=6 -> out_op_1_fpga=3, out_lu_miss=1; without the macro, op_1=5 -> fpga 1.
REQ-045 Reset mid-fill: count=3, rst high for 1 cycle -> count=0, queue_empty=1, out_valid=0, all lookup entries invalid.

Source files
------------

// File: rtl/iiq_pkg.sv
// iiq_pkg: width helpers and instruction-field offsets shared by the
// instruction issue queue and its operand lookup table.
// Instruction word layout, MSB first:
//   {start_time, op_code[1:0], op_1, op_2, dest, status[1:0]}
package iiq_pkg;

  localparam int STATUS_W   = 2;
  localparam int OPCODE_W   = 2;
  localparam int STATUS_LSB = 0;
  localparam int DEST_LSB   = STATUS_LSB + STATUS_W;

  // Operand width: enough bits to name every qubit in the system.
  function automatic int opw_f(input int num_fpga, input int num_qubit_per_fpga);
    return $clog2(num_fpga * num_qubit_per_fpga);
  endfunction

  // FPGA index width.
  function automatic int fw_f(input int num_fpga);
    return $clog2(num_fpga);
  endfunction

  // Full instruction word width.
  function automatic int iw_f(input int time_w, input int opw);
    return time_w + OPCODE_W + 3 * opw + STATUS_W;
  endfunction

  // Field LSB offsets; they depend on the operand width.
  function automatic int op2_lsb_f(input int opw);
    return DEST_LSB + opw;
  endfunction

  function automatic int op1_lsb_f(input int opw);
    return DEST_LSB + 2 * opw;
  endfunction

  function automatic int opcode_lsb_f(input int opw);
    return DEST_LSB + 3 * opw;
  endfunction

  function automatic int time_lsb_f(input int opw);
    return opcode_lsb_f(opw) + OPCODE_W;
  endfunction

endpackage

// File: rtl/instr_issue_queue_oplu_table.sv
// oplu_table: operand -> FPGA index map with one write port and NUM_RD
// combinational read ports. A write lands at the clock edge, so a read of
// the same address in the writing cycle still sees the old contents.
// Only the valid bits are cleared by reset; the FPGA indices are plain storage.
module oplu_table #(
  parameter int OPW    = 12,
  parameter int FW     = 6,
  parameter int NUM_RD = 3
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [OPW-1:0]               wr_addr,
  input  logic [FW-1:0]                wr_fpga,
  input  logic [NUM_RD-1:0][OPW-1:0]   rd_addr,
  output logic [NUM_RD-1:0][FW-1:0]    rd_fpga,
  output logic [NUM_RD-1:0]            rd_hit
);

  localparam int NUM_OPERANDS = 2 ** OPW;

  logic [FW-1:0]           fpga_mem [NUM_OPERANDS];
  logic [NUM_OPERANDS-1:0] valid_reg;

  // FPGA index storage: written on strobe, never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      fpga_mem[wr_addr] <= wr_fpga;
    end
  end

  // Valid bits: cleared on reset, set by each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (we) begin
      valid_reg[wr_addr] <= 1'b1;
    end
  end

  // Read ports: an invalid entry reads as FPGA 0 with hit low.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_hit[gi]  = valid_reg[rd_addr[gi]];
      assign rd_fpga[gi] = rd_hit[gi] ? fpga_mem[rd_addr[gi]] : '0;
    end
  endgenerate

endmodule

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: in-order instruction queue whose head issues only once
// a free-running (saturating) time counter reaches its start_time.
// Build option: define IIQ_OPLU_EN to map operands to FPGAs through a
// writable lookup table; otherwise the FPGA index is the operand's top bits.
module instr_issue_queue
  import iiq_pkg::*;
#(
  parameter int DEPTH              = 64,
  parameter int NUM_FPGA           = 64,
  parameter int NUM_QUBIT_PER_FPGA = 64,
  parameter int TIME_W             = 16,
  localparam int OPW = opw_f(NUM_FPGA, NUM_QUBIT_PER_FPGA),
  localparam int FW  = fw_f(NUM_FPGA),
  localparam int PW  = $clog2(DEPTH),
  localparam int IW  = iw_f(TIME_W, OPW)
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  in_instr,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_op_code,
  output logic [OPW-1:0] out_op_1,
  output logic [OPW-1:0] out_op_2,
  output logic [OPW-1:0] out_dest,
  output logic [FW-1:0]  out_op_1_fpga,
  output logic [FW-1:0]  out_op_2_fpga,
  output logic [FW-1:0]  out_dest_fpga,
  output logic           out_lu_miss,
  input  logic           lu_we,
  input  logic [OPW-1:0] lu_addr,
  input  logic [FW-1:0]  lu_fpga,
  output logic [PW:0]    count,
  output logic           queue_full,
  output logic           queue_empty,
  output logic           wrap_around
);

  localparam int TIME_LSB   = time_lsb_f(OPW);
  localparam int OPCODE_LSB = opcode_lsb_f(OPW);
  localparam int OP1_LSB    = op1_lsb_f(OPW);
  localparam int OP2_LSB    = op2_lsb_f(OPW);

  logic [PW:0]       head_reg, head_next;
  logic [PW:0]       tail_reg, tail_next;
  logic [TIME_W-1:0] time_reg;
  logic [IW-1:0]     queue_mem [DEPTH];
  logic [IW-1:0]     head_entry;
  logic [IW-1:0]     wr_entry;
  logic              do_enq;
  logic              do_deq;
  logic              ptr_low_eq;
  logic              unused_bits;

  // Status flags from the extra pointer MSB: differing MSBs mean the tail has
  // lapped the head once, which separates full from empty.
  assign ptr_low_eq  = (head_reg[PW-1:0] == tail_reg[PW-1:0]);
  assign wrap_around = head_reg[PW] ^ tail_reg[PW];
  assign queue_full  = wrap_around & ptr_low_eq;
  assign queue_empty = ~wrap_around & ptr_low_eq;
  assign count       = tail_reg - head_reg;
  assign in_ready    = ~queue_full;

  // Head view is read straight from storage so the fields track the head
  // even while it is still time-gated.
  assign head_entry  = queue_mem[head_reg[PW-1:0]];
  assign out_valid   = ~queue_empty && (head_entry[TIME_LSB +: TIME_W] <= time_reg);
  assign out_op_code = head_entry[OPCODE_LSB +: OPCODE_W];
  assign out_op_1    = head_entry[OP1_LSB +: OPW];
  assign out_op_2    = head_entry[OP2_LSB +: OPW];
  assign out_dest    = head_entry[DEST_LSB +: OPW];

  assign do_enq    = in_valid & in_ready;
  assign do_deq    = out_valid & out_ready;
  assign head_next = head_reg + (PW+1)'(do_deq);
  assign tail_next = tail_reg + (PW+1)'(do_enq);

  // Entries are stored with status cleared.
  assign wr_entry = {in_instr[IW-1:STATUS_W], {STATUS_W{1'b0}}};

  // Pointer registers; reset empties the queue and drops any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // Queue storage write at the tail; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      queue_mem[tail_reg[PW-1:0]] <= wr_entry;
    end
  end

  // Free-running time counter that sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_reg <= '0;
    end else if (time_reg != {TIME_W{1'b1}}) begin
      time_reg <= time_reg + 1'b1;
    end
  end

`ifdef IIQ_OPLU_EN
  logic [2:0][OPW-1:0] lu_rd_addr;
  logic [2:0][FW-1:0]  lu_rd_fpga;
  logic [2:0]          lu_rd_hit;

  // Read port order: 0 = op_1, 1 = op_2, 2 = dest.
  assign lu_rd_addr = {out_dest, out_op_2, out_op_1};

  oplu_table #(
    .OPW    (OPW),
    .FW     (FW),
    .NUM_RD (3)
  ) u_oplu_table (
    .clk     (clk),
    .rst     (rst),
    .we      (lu_we),
    .wr_addr (lu_addr),
    .wr_fpga (lu_fpga),
    .rd_addr (lu_rd_addr),
    .rd_fpga (lu_rd_fpga),
    .rd_hit  (lu_rd_hit)
  );

  assign out_op_1_fpga = lu_rd_fpga[0];
  assign out_op_2_fpga = lu_rd_fpga[1];
  assign out_dest_fpga = lu_rd_fpga[2];
  // A miss flags the instruction but does not hold it back.
  assign out_lu_miss   = ~&lu_rd_hit;
  assign unused_bits   = ^head_entry[STATUS_W-1:0];
`else
  logic [2:0][OPW-1:0] opnd;
  logic [2:0][FW-1:0]  opnd_fpga;

  assign opnd = {out_dest, out_op_2, out_op_1};

  // Fixed mapping: qubits are numbered FPGA-major, so the top bits name the FPGA.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fpga
      assign opnd_fpga[gi] = opnd[gi][OPW-1 -: FW];
    end
  endgenerate

  assign out_op_1_fpga = opnd_fpga[0];
  assign out_op_2_fpga = opnd_fpga[1];
  assign out_dest_fpga = opnd_fpga[2];
  assign out_lu_miss   = 1'b0;
  assign unused_bits   = ^{head_entry[STATUS_W-1:0], lu_we, lu_addr, lu_fpga};
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: directed vectors for instr_issue_queue
// (DEPTH=4, 4 FPGAs x 4 qubits, TIME_W=16) checked against a queue-level
// model every cycle plus literal expectations. Define IIQ_OPLU_EN to cover
// the lookup-table build.
module tb_instr_issue_queue;

  localparam int DEPTH = 4;
  localparam int NF    = 4;
  localparam int NQ    = 4;
  localparam int TW    = 16;
  localparam int OPW   = 4;
  localparam int FW    = 2;
  localparam int PW    = 2;
  localparam int IW    = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IW-1:0]  in_instr = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_op_code;
  logic [OPW-1:0] out_op_1, out_op_2, out_dest;
  logic [FW-1:0]  out_op_1_fpga, out_op_2_fpga, out_dest_fpga;
  logic           out_lu_miss;
  logic           lu_we = 1'b0;
  logic [OPW-1:0] lu_addr = '0;
  logic [FW-1:0]  lu_fpga = '0;
  logic [PW:0]    count;
  logic           queue_full, queue_empty, wrap_around;

  int total = 0;
  int bad   = 0;

  instr_issue_queue #(
    .DEPTH(DEPTH), .NUM_FPGA(NF), .NUM_QUBIT_PER_FPGA(NQ), .TIME_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_op_code(out_op_code), .out_op_1(out_op_1), .out_op_2(out_op_2),
    .out_dest(out_dest), .out_op_1_fpga(out_op_1_fpga),
    .out_op_2_fpga(out_op_2_fpga), .out_dest_fpga(out_dest_fpga),
    .out_lu_miss(out_lu_miss), .lu_we(lu_we), .lu_addr(lu_addr),
    .lu_fpga(lu_fpga), .count(count), .queue_full(queue_full),
    .queue_empty(queue_empty), .wrap_around(wrap_around)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    int unsigned st;
    int unsigned opc;
    int unsigned o1;
    int unsigned o2;
    int unsigned d;
  } ent_t;

  ent_t        mq[$];
  int unsigned mtime   = 0;
  int unsigned enq_tot = 0;
  int unsigned deq_tot = 0;
  int unsigned mlu_fpga [16];
  bit          mlu_valid[16];
  bit          model_live = 1'b0;

  function automatic ent_t decode(input logic [31:0] w);
    ent_t e;
    e.st  = int'(w[31:16]);
    e.opc = int'(w[15:14]);
    e.o1  = int'(w[13:10]);
    e.o2  = int'(w[9:6]);
    e.d   = int'(w[5:2]);
    return e;
  endfunction

  function automatic logic [31:0] mk(input int st, input int opc, input int o1,
                                     input int o2, input int d, input int stat);
    logic [31:0] w;
    w = {st[15:0], opc[1:0], o1[3:0], o2[3:0], d[3:0], stat[1:0]};
    return w;
  endfunction

  function automatic bit head_ready();
    return (mq.size() > 0) && (mq[0].st <= mtime);
  endfunction

  function automatic int unsigned exp_fpga(input int unsigned op);
`ifdef IIQ_OPLU_EN
    return mlu_valid[op] ? mlu_fpga[op] : 0;
`else
    return op / NQ;
`endif
  endfunction

  function automatic int unsigned exp_miss(input ent_t e);
`ifdef IIQ_OPLU_EN
    return (mlu_valid[e.o1] && mlu_valid[e.o2] && mlu_valid[e.d]) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Model update at each clock edge from the same inputs the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mtime   <= 0;
      enq_tot <= 0;
      deq_tot <= 0;
      for (int i = 0; i < 16; i++) mlu_valid[i] <= 1'b0;
      model_live <= 1'b1;
    end else begin
      if (out_ready && head_ready()) begin
        if (in_valid && mq.size() < DEPTH) begin
          mq.pop_front();
          mq.push_back(decode(in_instr));
          enq_tot <= enq_tot + 1;
        end else begin
          mq.pop_front();
        end
        deq_tot <= deq_tot + 1;
      end else if (in_valid && mq.size() < DEPTH) begin
        mq.push_back(decode(in_instr));
        enq_tot <= enq_tot + 1;
      end
      if (mtime != 65535) mtime <= mtime + 1;
      if (lu_we) begin
        mlu_fpga[lu_addr]  <= int'(lu_fpga);
        mlu_valid[lu_addr] <= 1'b1;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (model_live && !rst) begin
      chk("count", count, mq.size());
      chk("empty", queue_empty, (mq.size() == 0) ? 1 : 0);
      chk("full", queue_full, (mq.size() == DEPTH) ? 1 : 0);
      chk("in_ready", in_ready, (mq.size() < DEPTH) ? 1 : 0);
      chk("wrap", wrap_around, ((enq_tot / DEPTH) + (deq_tot / DEPTH)) % 2);
      chk("out_valid", out_valid, head_ready() ? 1 : 0);
      if (mq.size() > 0) begin
        chk("op_code", out_op_code, mq[0].opc);
        chk("op_1", out_op_1, mq[0].o1);
        chk("op_2", out_op_2, mq[0].o2);
        chk("dest", out_dest, mq[0].d);
        chk("op_1_fpga", out_op_1_fpga, exp_fpga(mq[0].o1));
        chk("op_2_fpga", out_op_2_fpga, exp_fpga(mq[0].o2));
        chk("dest_fpga", out_dest_fpga, exp_fpga(mq[0].d));
        chk("lu_miss", out_lu_miss, exp_miss(mq[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lu_we     = 1'b0;
    rst       = 1'b1;
    cyc();
    rst       = 1'b0;
  endtask

  task automatic enq(input logic [31:0] w);
    in_instr = w;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    do_reset();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", queue_empty, 1);
    chk("rst_full", queue_full, 0);
    chk("rst_wrap", wrap_around, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
`ifdef IIQ_OPLU_EN
    chk("rst_lu_miss", out_lu_miss, 1);
`else
    chk("rst_lu_miss", out_lu_miss, 0);
`endif

    // Fill: four entries, then a fifth offer that must be dropped
    for (int i = 0; i < 4; i++) enq(mk(0, i, i + 1, i + 8, 15 - i, 3));
    chk("fill_count", count, 4);
    chk("fill_full", queue_full, 1);
    chk("fill_wrap", wrap_around, 1);
    chk("fill_in_ready", in_ready, 0);
    enq(mk(0, 0, 9, 9, 9, 0));
    chk("fill_drop_count", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_op_1", out_op_1, i + 1);
      cyc();
    end
    out_ready = 1'b0;
    chk("drain_empty", queue_empty, 1);

    // Time gate: start_time 10 enqueued in the first cycle after reset
    do_reset();
    enq(mk(10, 2, 3, 4, 5, 0));
    for (int t = 1; t < 10; t++) begin
      chk("gate_low", out_valid, 0);
      cyc();
    end
    chk("gate_high", out_valid, 1);
    chk("gate_op_code", out_op_code, 2);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("gate_pop_count", count, 0);

    // Wrap: six enqueue/dequeue pairs from pointer 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enq(mk(0, 1, (3 * i + 1) % 16, i, 7, 0));
      chk("wrap_after_enq", wrap_around, (i == 3) ? 1 : 0);
      chk("wrap_head_op_1", out_op_1, (3 * i + 1) % 16);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("wrap_after_deq", wrap_around, 0);
    end

    // Simultaneous enqueue/dequeue at count 2 and at count 4
    do_reset();
    enq(mk(0, 0, 1, 1, 1, 0));
    enq(mk(0, 0, 2, 2, 2, 0));
    in_instr = mk(0, 0, 3, 3, 3, 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("sim2_count", count, 2);
    chk("sim2_head", out_op_1, 2);
    enq(mk(0, 0, 4, 4, 4, 0));
    enq(mk(0, 0, 5, 5, 5, 0));
    chk("sim4_pre_count", count, 4);
    in_instr = mk(0, 0, 6, 6, 6, 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("sim4_count", count, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("sim4_order", out_op_1, 3 + i);
      cyc();
    end
    out_ready = 1'b0;
    chk("sim4_empty", queue_empty, 1);

    // Lookup: op 5 -> FPGA 3, op 6 left unmapped
    do_reset();
    enq(mk(0, 1, 5, 6, 5, 0));
    lu_we = 1'b1;
    lu_addr = 4'd5;
    lu_fpga = 2'd3;
`ifdef IIQ_OPLU_EN
    chk("lu_same_cycle_old", out_op_1_fpga, 0);
`endif
    cyc();
    lu_we = 1'b0;
`ifdef IIQ_OPLU_EN
    chk("lu_op_1_fpga", out_op_1_fpga, 3);
    chk("lu_dest_fpga", out_dest_fpga, 3);
    chk("lu_op_2_fpga", out_op_2_fpga, 0);
    chk("lu_miss_set", out_lu_miss, 1);
`else
    chk("lu_op_1_fpga", out_op_1_fpga, 1);
    chk("lu_op_2_fpga", out_op_2_fpga, 1);
    chk("lu_miss_set", out_lu_miss, 0);
`endif
    lu_we = 1'b1;
    lu_addr = 4'd6;
    lu_fpga = 2'd2;
    cyc();
    lu_we = 1'b0;
`ifdef IIQ_OPLU_EN
    chk("lu_op_2_mapped", out_op_2_fpga, 2);
    chk("lu_miss_clear", out_lu_miss, 0);
`else
    chk("lu_op_2_ignored", out_op_2_fpga, 1);
`endif
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Reset mid-fill with a handshake offered during the reset cycle
    for (int i = 0; i < 3; i++) enq(mk(0, 0, 5, 6, 5, 0));
    chk("mid_pre_count", count, 3);
    in_instr = mk(0, 0, 7, 7, 7, 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mid_count", count, 0);
    chk("mid_empty", queue_empty, 1);
    chk("mid_out_valid", out_valid, 0);
    enq(mk(0, 0, 5, 6, 5, 0));
`ifdef IIQ_OPLU_EN
    chk("mid_lu_invalid", out_lu_miss, 1);
    chk("mid_lu_fpga", out_op_1_fpga, 0);
`else
    chk("mid_lu_fpga", out_op_1_fpga, 1);
`endif
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
